// File: rtl/ex_pkg.sv
// Shared execute-side definitions: ALU operation codes, ALUOp classes,
// the R-type opcodes the ALU control understands, and control-bit positions.
package ex_pkg;

   localparam int DATA_W = 64;
   localparam int REG_AW = 5;
   localparam int CTRL_W = 5;

   // 4-bit ALU operation codes consumed by the execute ALU.
   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_ORR  = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0110,
      ALU_PASS = 4'b0111,
      ALU_NOR  = 4'b1100
   } alu_op_e;

   // Instruction class from the main decoder.
   typedef enum logic [1:0] {
      ALUOP_MEM   = 2'b00,
      ALUOP_CBZ   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_RSVD  = 2'b11
   } aluop_e;

   // instruction[31:21] for the supported R-type operations.
   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;

   // Bit positions within {Branch, MemRead, MemWrite, RegWrite, MemtoReg}.
   localparam int CTRL_BRANCH   = 4;
   localparam int CTRL_MEMREAD  = 3;
   localparam int CTRL_MEMWRITE = 2;
   localparam int CTRL_REGWRITE = 1;
   localparam int CTRL_MEMTOREG = 0;

   // Remove the architecturally visible side effects of an instruction.
   function automatic logic [CTRL_W-1:0] squash_ctrl(input logic [CTRL_W-1:0] ctrl);
      logic [CTRL_W-1:0] res;
      res                = ctrl;
      res[CTRL_MEMWRITE] = 1'b0;
      res[CTRL_REGWRITE] = 1'b0;
      return res;
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: upstream handshake and operands, downstream
// handshake and registered ALU inputs. "slave" is the stage's view.
interface id_ex_stage_if #(
   parameter int DATA_W = 64,
   parameter int REG_AW = 5
);
   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both 1; valid must not depend on ready, and ready may depend on valid.
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_rdata1;
   logic [DATA_W-1:0] in_rdata2;
   logic [DATA_W-1:0] in_imm;
   logic              in_alusrc;
   logic [1:0]        in_aluop;
   logic [10:0]       in_opcode;
   logic [REG_AW-1:0] in_rd;
   logic [4:0]        in_ctrl;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] alu_in1;
   logic [DATA_W-1:0] alu_in2;
   logic [3:0]        alu_op;
   logic [DATA_W-1:0] out_store_data;
   logic [REG_AW-1:0] out_rd;
   logic [4:0]        out_ctrl;
   logic              out_illegal;

   modport slave (
      input  in_valid, in_rdata1, in_rdata2, in_imm, in_alusrc, in_aluop,
             in_opcode, in_rd, in_ctrl, flush, out_ready,
      output in_ready, out_valid, alu_in1, alu_in2, alu_op, out_store_data,
             out_rd, out_ctrl, out_illegal
   );

   modport master (
      output in_valid, in_rdata1, in_rdata2, in_imm, in_alusrc, in_aluop,
             in_opcode, in_rd, in_ctrl, flush, out_ready,
      input  in_ready, out_valid, alu_in1, alu_in2, alu_op, out_store_data,
             out_rd, out_ctrl, out_illegal
   );

endinterface

// File: rtl/alu_ctrl_decode.sv
// ALU control: ALUOp class plus R-type opcode to 4-bit ALU operation.
// Unknown R-type opcodes and the reserved class decode as ADD and are flagged.
module alu_ctrl_decode
   import ex_pkg::*;
(
   input  logic [1:0]  aluop,
   input  logic [10:0] opcode,
   output logic [3:0]  alu_op,
   output logic        illegal
);

   // Pure table lookup; ADD is the safe default for anything flagged illegal.
   always_comb begin
      alu_op  = ALU_ADD;
      illegal = 1'b0;
      case (aluop)
         ALUOP_MEM:   alu_op = ALU_ADD;
         ALUOP_CBZ:   alu_op = ALU_PASS;
         ALUOP_RTYPE: begin
            case (opcode)
               OPC_ADD: alu_op = ALU_ADD;
               OPC_SUB: alu_op = ALU_SUB;
               OPC_AND: alu_op = ALU_AND;
               OPC_ORR: alu_op = ALU_ORR;
               default: illegal = 1'b1;
            endcase
         end
         default:     illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register in front of the 64-bit ALU. Single-entry stage:
// accepts when empty or when the held instruction retires in the same edge.
module id_ex_stage
   import ex_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int REG_AW = 5
) (
   input  logic          clk,
   input  logic          reset_n,
   id_ex_stage_if.slave  bus
);

   logic              valid_q;
   logic [DATA_W-1:0] in1_q;
   logic [DATA_W-1:0] in2_q;
   logic [DATA_W-1:0] store_q;
   logic [3:0]        op_q;
   logic [REG_AW-1:0] rd_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic              illegal_q;

   logic [3:0]        dec_op;
   logic              dec_illegal;
   logic              load;

   alu_ctrl_decode u_dec (
      .aluop   (bus.in_aluop),
      .opcode  (bus.in_opcode),
      .alu_op  (dec_op),
      .illegal (dec_illegal)
   );

   // No skid buffer: ready only when empty or draining this cycle.
   assign bus.in_ready = !valid_q || bus.out_ready;
   assign load         = bus.in_valid && bus.in_ready && !bus.flush;

   // Stage register: reset beats flush, flush beats load, otherwise hold or drain.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q   <= 1'b0;
         in1_q     <= '0;
         in2_q     <= '0;
         store_q   <= '0;
         op_q      <= '0;
         rd_q      <= '0;
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
      end else if (load) begin
         valid_q   <= 1'b1;
         in1_q     <= bus.in_rdata1;
         in2_q     <= bus.in_alusrc ? bus.in_imm : bus.in_rdata2;
         store_q   <= bus.in_rdata2;
         op_q      <= dec_op;
         rd_q      <= bus.in_rd;
         ctrl_q    <= dec_illegal ? squash_ctrl(bus.in_ctrl) : bus.in_ctrl;
         illegal_q <= dec_illegal;
      end else if (bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.out_valid      = valid_q;
   assign bus.alu_in1        = in1_q;
   assign bus.alu_in2        = in2_q;
   assign bus.out_store_data = store_q;
   assign bus.alu_op         = op_q;
   assign bus.out_rd         = rd_q;
   assign bus.out_ctrl       = ctrl_q;
   assign bus.out_illegal    = illegal_q;

endmodule
